cpu_mem_arb: RTL

- Shares the core's single memory request port between the instruction fetch stage (IL1 side) and the memory stage (DL1 side).
- Arbitrates between the two requesters and drives one outstanding transaction at a time.
- Routes the acknowledge and read data back to the requester that owns the transaction.
- Detects hung transactions with a watchdog.
- Sits between the fetch/memory pipeline stages and the L1/bus interface.

---
 rtl/cpu_mem_pkg.sv | 30 +++
 rtl/cpu_mem_arb_rr.sv | 30 +++
 rtl/cpu_mem_arb.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the core memory port arbiter: FSM states, owner
// codes, size codes (same encoding as the decoder) and the bit layout of the
// data-side memory-op field {cacheable, we, rsvd, size[2:0]}.
package cpu_mem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned COP_W  = 6;
    localparam int unsigned SIZE_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Transaction owner, also the bit index into the eligible/grant vectors
    localparam logic SRC_IF = 1'b0;
    localparam logic SRC_DL = 1'b1;

    localparam logic [SIZE_W-1:0] SZ_BYTE = 3'b000;
    localparam logic [SIZE_W-1:0] SZ_HALF = 3'b001;
    localparam logic [SIZE_W-1:0] SZ_WORD = 3'b010;

    localparam int unsigned COP_CACHE_BIT = 5;
    localparam int unsigned COP_WE_BIT    = 4;
    localparam int unsigned COP_RSVD_BIT  = 3;
    localparam int unsigned COP_SIZE_MSB  = 2;
    localparam int unsigned COP_SIZE_LSB  = 0;

endpackage

// File: rtl/cpu_mem_arb_rr.sv
// Two-way arbiter for the memory port.
//   elig       : eligible requesters, bit SRC_IF = fetch, bit SRC_DL = data
//   last_grant : owner of the most recent grant
//   grant_c    : one-hot grant (combinational), zero when nobody is eligible
// ARB_MODE 0 gives data fixed priority; 1 alternates on contention.
module cpu_mem_arb_rr
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ARB_MODE = 1
) (
    input  logic [1:0] elig,
    input  logic       last_grant,
    output logic [1:0] grant_c
);

    // Contention is resolved by mode; a single requester always wins
    always_comb begin
        grant_c = 2'b00;
        if (elig == 2'b11) begin
            if ((ARB_MODE == 0) || (last_grant == SRC_IF)) begin
                grant_c[SRC_DL] = 1'b1;
            end else begin
                grant_c[SRC_IF] = 1'b1;
            end
        end else begin
            grant_c = elig;
        end
    end

endmodule

// File: rtl/cpu_mem_arb.sv
// Shares the core's single memory request port between fetch and the memory
// stage, one outstanding transaction at a time, with a hang watchdog.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   i_req_val/i_req_addr/i_kill   : fetch request and flush
//   i_ack/i_rdata                 : fetch completion (combinational pulse)
//   d_req_val/addr/cop/wdata      : data request, cop = {cacheable,we,rsvd,size}
//   d_ack/d_rdata                 : data completion (combinational pulse)
//   mem_req_*                     : registered request to memory, src = owner
//   mem_ack/mem_rdata             : memory completion
//   timeout_err                   : sticky watchdog flag
module cpu_mem_arb
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ARB_MODE    = 1,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_val,
    input  logic [31:0] i_req_addr,
    input  logic        i_kill,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req_val,
    input  logic [31:0] d_req_addr,
    input  logic [5:0]  d_req_cop,
    input  logic [31:0] d_req_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        mem_req_val,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_we,
    output logic [2:0]  mem_req_size,
    output logic        mem_req_cacheable,
    output logic [31:0] mem_req_wdata,
    output logic        mem_req_src,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        timeout_err
);

    arb_state_t       state;
    logic             last_grant;
    logic             kill_pend;
    logic [CNT_W-1:0] wd_cnt;

    logic [1:0] elig_c;
    logic [1:0] grant_c;
    logic       wd_hit_c;
    logic       done_c;
    logic       kill_c;
    logic       rsvd_unused;

    // The reserved cop bit carries no meaning for the memory port
    assign rsvd_unused = d_req_cop[COP_RSVD_BIT];

    // A flushed fetch is not allowed to start a transaction
    assign elig_c = {d_req_val, i_req_val & ~i_kill};

    cpu_mem_arb_rr #(
        .ARB_MODE (ARB_MODE)
    ) u_rr (
        .elig       (elig_c),
        .last_grant (last_grant),
        .grant_c    (grant_c)
    );

    // Completion decode and ack/rdata routing; mem_ack beats the watchdog
    always_comb begin
        wd_hit_c = 1'b0;
        done_c   = 1'b0;
        kill_c   = 1'b0;
        i_ack    = 1'b0;
        d_ack    = 1'b0;
        i_rdata  = '0;
        d_rdata  = '0;
        if (state == ST_BUSY) begin
            wd_hit_c = (TIMEOUT_CYC != 0) && !mem_ack &&
                       (wd_cnt == CNT_W'(TIMEOUT_CYC));
            done_c   = mem_ack | wd_hit_c;
            kill_c   = (mem_req_src == SRC_IF) && (kill_pend || i_kill);
            if (done_c) begin
                if (mem_req_src == SRC_DL) begin
                    d_ack   = 1'b1;
                    d_rdata = mem_ack ? mem_rdata : '0;
                end else if (!kill_c) begin
                    i_ack   = 1'b1;
                    i_rdata = mem_ack ? mem_rdata : '0;
                end
            end
        end
    end

    // Transaction FSM with registered memory request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= ST_IDLE;
            last_grant        <= SRC_IF;
            kill_pend         <= 1'b0;
            wd_cnt            <= '0;
            timeout_err       <= 1'b0;
            mem_req_val       <= 1'b0;
            mem_req_addr      <= '0;
            mem_req_we        <= 1'b0;
            mem_req_size      <= '0;
            mem_req_cacheable <= 1'b0;
            mem_req_wdata     <= '0;
            mem_req_src       <= SRC_IF;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_c != 2'b00) begin
                        state       <= ST_BUSY;
                        mem_req_val <= 1'b1;
                        wd_cnt      <= '0;
                        kill_pend   <= 1'b0;
                        if (grant_c[SRC_DL]) begin
                            mem_req_src       <= SRC_DL;
                            last_grant        <= SRC_DL;
                            mem_req_addr      <= d_req_addr;
                            mem_req_we        <= d_req_cop[COP_WE_BIT];
                            mem_req_size      <= d_req_cop[COP_SIZE_MSB:COP_SIZE_LSB];
                            mem_req_cacheable <= d_req_cop[COP_CACHE_BIT];
                            mem_req_wdata     <= d_req_wdata;
                        end else begin
                            // Fetches are always cacheable word reads
                            mem_req_src       <= SRC_IF;
                            last_grant        <= SRC_IF;
                            mem_req_addr      <= i_req_addr;
                            mem_req_we        <= 1'b0;
                            mem_req_size      <= SZ_WORD;
                            mem_req_cacheable <= 1'b1;
                            mem_req_wdata     <= '0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (done_c) begin
                        state       <= ST_IDLE;
                        mem_req_val <= 1'b0;
                        kill_pend   <= 1'b0;
                        if (wd_hit_c) begin
                            timeout_err <= 1'b1;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                        if ((mem_req_src == SRC_IF) && i_kill) begin
                            kill_pend <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
